spi_regif_slave: RTL and testbench

SPI slave register-access port: the device-side end of the host's 48-bit SPI register protocol (16-bit header + 32-bit data). It oversamples the SPI pins on the system clock, decodes write and read frames, and drives a single-cycle register bus toward the control and status registers of the FOC/SVPWM core. Read data is shifted back on MISO in the same frame.

---
 rtl/spi_regif_slave_if.sv | 21 ++
 rtl/spi_regif_slave.sv | 203 ++++++++++++++++++++
 tb/tb_spi_regif_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regif_slave_if.sv
// Register-bus bundle between the SPI slave port and the FOC/SVPWM register file.
// reg_we/reg_re are single-cycle strobes with reg_addr (and reg_wdata) valid that cycle; a read
// completes when the register file answers with a one-cycle reg_rvalid carrying reg_rdata.
interface spi_regif_slave_if;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata, reg_rvalid
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata, reg_rvalid
  );
endinterface

// File: rtl/spi_regif_slave.sv
// SPI slave for the 48-bit register protocol (16-bit header + 32-bit data), oversampled on clk,
// issuing single-cycle register-bus writes/reads and returning read data on MISO in the same frame.
module spi_regif_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] WR_CMD      = 4'b0100,
  parameter logic [3:0] RD_CMD      = 4'b0000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_cs,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       frame_err,
  output logic [2:0] state_dbg,
  spi_regif_slave_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic cs_prev_q, sclk_prev_q;
  logic cs_rise_q, cs_fall_q, sclk_rise_q, mosi_q;

  // Sync chains reset to 0 so a cs already low at reset release never looks like a new frame start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_rise_q   <= cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
      cs_fall_q   <= ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
    end
  end

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [11:0] addr_q, addr_d;
  logic        miso_q, miso_d, oe_q, oe_d;
  logic        we_q, we_d, re_q, re_d, err_q, err_d;
  logic        pend_q, pend_d, have_q, have_d;
  logic [15:0] hdr;
  logic [31:0] tx_src;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      have_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      re_q    <= re_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      have_q  <= have_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    miso_d  = miso_q;
    oe_d    = oe_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    err_d   = 1'b0;
    pend_d  = pend_q;
    have_d  = have_q;
    hdr     = {rx_q[14:0], mosi_q};
    tx_src  = tx_q;

    if (state_q == ST_RDATA && pend_q && bus.reg_rvalid) begin
      tx_d   = bus.reg_rdata;
      pend_d = 1'b0;
      have_d = 1'b1;
    end

    if (sclk_rise_q) begin
      case (state_q)
        ST_HDR: begin
          rx_d  = {rx_q[30:0], mosi_q};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd15) begin
            addr_d = hdr[11:0];
            if (hdr[15:12] == WR_CMD) begin
              state_d = ST_WDATA;
            end else if (hdr[15:12] == RD_CMD) begin
              state_d = ST_RDATA;
              re_d    = 1'b1;
              pend_d  = 1'b1;
              have_d  = 1'b0;
            end else begin
              state_d = ST_DROP;
            end
          end
        end
        ST_WDATA: begin
          rx_d  = {rx_q[30:0], mosi_q};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd47) begin
            we_d    = 1'b1;
            wdata_d = {rx_q[30:0], mosi_q};
            state_d = ST_DROP;
          end
        end
        ST_RDATA: begin
          cnt_d = cnt_q + 6'd1;
          // First data rise: data answered this cycle or earlier is sent, otherwise zeros and an error.
          if (cnt_q == 6'd16) begin
            if (pend_q && bus.reg_rvalid) tx_src = bus.reg_rdata;
            else if (have_q)              tx_src = tx_q;
            else begin
              tx_src = '0;
              err_d  = 1'b1;
            end
            pend_d = 1'b0;
            oe_d   = 1'b1;
          end
          miso_d = tx_src[31];
          tx_d   = {tx_src[30:0], 1'b0};
          if (cnt_q == 6'd47) state_d = ST_DROP;
        end
        default: ;
      endcase
    end

    // The sclk rise above is applied first, so a frame finishing in the same cycle is not an abort.
    if (cs_rise_q) begin
      if ((state_d == ST_HDR && cnt_d != 6'd0) || state_d == ST_WDATA || state_d == ST_RDATA)
        err_d = 1'b1;
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      pend_d  = 1'b0;
      have_d  = 1'b0;
    end

    if (cs_fall_q) begin
      state_d = ST_HDR;
      cnt_d   = '0;
      rx_d    = '0;
      tx_d    = '0;
      pend_d  = 1'b0;
      have_d  = 1'b0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
    end
  end

  assign spi_miso      = miso_q;
  assign spi_miso_oe   = oe_q;
  assign frame_err     = err_q;
  assign state_dbg     = state_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;

endmodule

// File: tb/tb_spi_regif_slave.sv
// Directed bench for spi_regif_slave: SPI host driver, register-bus responder and pulse monitor.
module tb_spi_regif_slave;

  logic clk = 1'b0;
  logic rstn;
  logic spi_cs, spi_sclk, spi_mosi;
  logic spi_miso, spi_miso_oe, frame_err;
  logic [2:0] state_dbg;

  spi_regif_slave_if bus ();

  spi_regif_slave dut (
    .clk         (clk),
    .rstn        (rstn),
    .spi_cs      (spi_cs),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .frame_err   (frame_err),
    .state_dbg   (state_dbg),
    .bus         (bus)
  );

  // 50 MHz system clock; SCLK half period is 5 clk (5 MHz).
  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int we_cnt = 0, re_cnt = 0, err_cnt = 0;
  logic [11:0] we_addr = '0, re_addr = '0;
  logic [31:0] we_data = '0;

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.reg_we === 1'b1) begin
        we_cnt++;
        we_addr = bus.reg_addr;
        we_data = bus.reg_wdata;
      end
      if (bus.reg_re === 1'b1) begin
        re_cnt++;
        re_addr = bus.reg_addr;
      end
      if (frame_err === 1'b1) err_cnt++;
    end
  end

  // Register-file model: answers reg_re with reg_rvalid two clocks later when enabled.
  logic        resp_en = 1'b0;
  logic [31:0] resp_data = '0;
  int          resp_stage = 0;

  always @(negedge clk) begin
    if (resp_stage == 1) begin
      bus.reg_rvalid = 1'b1;
      bus.reg_rdata  = resp_data;
      resp_stage     = 0;
    end else begin
      bus.reg_rvalid = 1'b0;
      bus.reg_rdata  = '0;
    end
    if (bus.reg_re === 1'b1 && resp_en) resp_stage = 1;
  end

  logic oe_all_hi;

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    spi_cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic m);
    spi_mosi = b;
    half();
    spi_sclk = 1'b1;
    half();
    m = spi_miso;
    spi_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [47:0] w, input int first, input int n, output logic [31:0] rx);
    logic m;
    for (int i = first; i < first + n; i++) begin
      send_bit(w[47-i], m);
      if (i >= 16) begin
        rx = {rx[30:0], m};
        if (spi_miso_oe !== 1'b1) oe_all_hi = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [47:0] w, input int n, output logic [31:0] rx);
    rx = '0;
    oe_all_hi = 1'b1;
    cs_low();
    send_bits(w, 0, n, rx);
    cs_high();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    spi_cs = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    checks += 8;
    if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
    if (bus.reg_addr !== 12'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", bus.reg_addr); end
    if (bus.reg_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", bus.reg_wdata); end
    if (bus.reg_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.reg_we); end
    if (bus.reg_re !== 1'b0) begin failures++; $display("FAIL reset_re got=%b exp=0", bus.reg_re); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    if (state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write(input logic [15:0] h, input logic [31:0] d, input string name);
    int we0, re0, er0;
    logic [31:0] rx;
    we0 = we_cnt; re0 = re_cnt; er0 = err_cnt;
    send_frame({h, d}, 48, rx);
    checks += 5;
    if (we_cnt - we0 !== 1) begin failures++; $display("FAIL %s_we_count got=%0d exp=1", name, we_cnt - we0); end
    if (we_addr !== h[11:0]) begin failures++; $display("FAIL %s_addr got=%h exp=%h", name, we_addr, h[11:0]); end
    if (we_data !== d) begin failures++; $display("FAIL %s_wdata got=%h exp=%h", name, we_data, d); end
    if (err_cnt - er0 !== 0) begin failures++; $display("FAIL %s_err got=%0d exp=0", name, err_cnt - er0); end
    if (re_cnt - re0 !== 0) begin failures++; $display("FAIL %s_re got=%0d exp=0", name, re_cnt - re0); end
  endtask

  task automatic test_read();
    int re0, er0;
    logic [31:0] rx;
    re0 = re_cnt; er0 = err_cnt;
    resp_en = 1'b1;
    resp_data = 32'hA5A5_0F0F;
    send_frame({16'h0456, 32'h0}, 48, rx);
    checks += 6;
    if (rx !== 32'hA5A50F0F) begin failures++; $display("FAIL read_data got=%h exp=a5a50f0f", rx); end
    if (re_cnt - re0 !== 1) begin failures++; $display("FAIL read_re_count got=%0d exp=1", re_cnt - re0); end
    if (re_addr !== 12'h456) begin failures++; $display("FAIL read_addr got=%h exp=456", re_addr); end
    if (err_cnt - er0 !== 0) begin failures++; $display("FAIL read_err got=%0d exp=0", err_cnt - er0); end
    if (oe_all_hi !== 1'b1) begin failures++; $display("FAIL read_oe_during_data got=%b exp=1", oe_all_hi); end
    if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL read_oe_after_cs got=%b exp=0", spi_miso_oe); end
  endtask

  task automatic test_read_timeout();
    int re0, er0;
    logic [31:0] rx;
    re0 = re_cnt; er0 = err_cnt;
    resp_en = 1'b0;
    send_frame({16'h0010, 32'hFFFF_FFFF}, 48, rx);
    checks += 3;
    if (rx !== 32'h0) begin failures++; $display("FAIL timeout_data got=%h exp=00000000", rx); end
    if (err_cnt - er0 !== 1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - er0); end
    if (re_cnt - re0 !== 1) begin failures++; $display("FAIL timeout_re got=%0d exp=1", re_cnt - re0); end
  endtask

  task automatic test_abort();
    int we0, er0;
    logic [31:0] rx;
    we0 = we_cnt; er0 = err_cnt;
    send_frame({16'h4001, 32'hFFFF_0000}, 36, rx);
    checks += 2;
    if (we_cnt - we0 !== 0) begin failures++; $display("FAIL abort_we got=%0d exp=0", we_cnt - we0); end
    if (err_cnt - er0 !== 1) begin failures++; $display("FAIL abort_err got=%0d exp=1", err_cnt - er0); end
    test_write(16'h4002, 32'h1234_5678, "after_abort");
  endtask

  task automatic test_unknown_cmd();
    int we0, re0, er0;
    logic [31:0] rx;
    we0 = we_cnt; re0 = re_cnt; er0 = err_cnt;
    send_frame({16'h8FFF, 32'h5555_AAAA}, 48, rx);
    checks += 3;
    if (we_cnt - we0 !== 0) begin failures++; $display("FAIL unknown_we got=%0d exp=0", we_cnt - we0); end
    if (re_cnt - re0 !== 0) begin failures++; $display("FAIL unknown_re got=%0d exp=0", re_cnt - re0); end
    if (err_cnt - er0 !== 0) begin failures++; $display("FAIL unknown_err got=%0d exp=0", err_cnt - er0); end
  endtask

  task automatic test_reset_mid_read();
    int we0, er0;
    logic [31:0] rx;
    resp_en = 1'b1;
    resp_data = 32'h1357_9BDF;
    rx = '0;
    oe_all_hi = 1'b1;
    cs_low();
    send_bits({16'h0456, 32'h0}, 0, 26, rx);
    checks += 3;
    if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL midrd_oe_before got=%b exp=1", spi_miso_oe); end
    if (bus.reg_addr !== 12'h456) begin failures++; $display("FAIL midrd_addr_before got=%h exp=456", bus.reg_addr); end
    if (rx[9:0] !== 10'b0001001101) begin failures++; $display("FAIL midrd_bits got=%b exp=0001001101", rx[9:0]); end
    rstn = 1'b0;
    #1;
    checks += 6;
    if (spi_miso !== 1'b0) begin failures++; $display("FAIL midrd_miso got=%b exp=0", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL midrd_oe got=%b exp=0", spi_miso_oe); end
    if (bus.reg_addr !== 12'h000) begin failures++; $display("FAIL midrd_addr got=%h exp=000", bus.reg_addr); end
    if (bus.reg_re !== 1'b0) begin failures++; $display("FAIL midrd_re got=%b exp=0", bus.reg_re); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL midrd_err got=%b exp=0", frame_err); end
    if (state_dbg !== 3'd0) begin failures++; $display("FAIL midrd_state got=%0d exp=0", state_dbg); end
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    we0 = we_cnt; er0 = err_cnt;
    send_bits({16'h0456, 32'h0}, 26, 22, rx);
    cs_high();
    checks += 2;
    if (we_cnt - we0 !== 0) begin failures++; $display("FAIL midrd_tail_we got=%0d exp=0", we_cnt - we0); end
    if (err_cnt - er0 !== 0) begin failures++; $display("FAIL midrd_tail_err got=%0d exp=0", err_cnt - er0); end
    test_write(16'h4777, 32'hCAFE_F00D, "after_reset");
  endtask

  initial begin
    test_reset();
    test_write(16'h4123, 32'hDEAD_BEEF, "write");
    test_read();
    test_read_timeout();
    test_abort();
    test_unknown_cmd();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
